// File: rtl/serial_frame_rx.sv
// Asynchronous serial frame receiver: start-bit hunt, mid-bit sampling on an oversample
// strobe, LSB-first assembly, optional parity, stop check, one-entry valid/ready output.
`timescale 1ns/1ps
module serial_frame_rx #(
  parameter int DATA_WIDTH = 8,
  parameter int OVERSAMPLE = 16,
  parameter int PARITY_EN  = 0,
  parameter int PARITY_ODD = 0
) (
  input  logic                  clk_i,
  input  logic                  rst_i,
  input  logic                  clr_i,
  input  logic                  tick_i,
  input  logic                  rx_i,
  output logic [DATA_WIDTH-1:0] data_o,
  output logic                  valid_o,
  input  logic                  ready_i,
  output logic                  frame_err_o,
  output logic                  parity_err_o,
  output logic                  overrun_o,
  output logic                  busy_o
);

  localparam int TW = $clog2(OVERSAMPLE);
  localparam int BW = $clog2(DATA_WIDTH + 1);
  localparam logic [TW-1:0] MID_TICK  = TW'(OVERSAMPLE / 2 - 1);
  localparam logic [TW-1:0] LAST_TICK = TW'(OVERSAMPLE - 1);
  localparam logic [BW-1:0] LAST_BIT  = BW'(DATA_WIDTH - 1);
  localparam logic          ODD       = (PARITY_ODD != 0);

  typedef enum logic [2:0] {IDLE, START, DATA, PARITY, STOP, BREAK} state_t;

  state_t                state_q, state_d;
  logic [TW-1:0]         tick_q, tick_d;
  logic [BW-1:0]         bit_q, bit_d;
  logic [DATA_WIDTH-1:0] shreg_q, shreg_d;
  logic                  perr_q, perr_d;
  logic                  complete;

  always_comb begin
    state_d  = state_q;
    tick_d   = tick_q;
    bit_d    = bit_q;
    shreg_d  = shreg_q;
    perr_d   = perr_q;
    complete = 1'b0;
    if (tick_i) begin
      unique case (state_q)
        IDLE: begin
          // The detection tick is tick 0, so START continues counting from 1.
          if (!rx_i) begin
            state_d = START;
            tick_d  = TW'(1);
            perr_d  = 1'b0;
          end
        end
        START: begin
          if (tick_q == MID_TICK) begin
            tick_d  = '0;
            bit_d   = '0;
            state_d = rx_i ? IDLE : DATA;
          end else begin
            tick_d = tick_q + 1'b1;
          end
        end
        DATA: begin
          if (tick_q == LAST_TICK) begin
            tick_d  = '0;
            shreg_d = {rx_i, shreg_q[DATA_WIDTH-1:1]};
            bit_d   = bit_q + 1'b1;
            if (bit_q == LAST_BIT) state_d = (PARITY_EN != 0) ? PARITY : STOP;
          end else begin
            tick_d = tick_q + 1'b1;
          end
        end
        PARITY: begin
          if (tick_q == LAST_TICK) begin
            tick_d  = '0;
            perr_d  = (^shreg_q) ^ rx_i ^ ODD;
            state_d = STOP;
          end else begin
            tick_d = tick_q + 1'b1;
          end
        end
        STOP: begin
          if (tick_q == LAST_TICK) begin
            tick_d   = '0;
            complete = 1'b1;
            state_d  = rx_i ? IDLE : BREAK;
          end else begin
            tick_d = tick_q + 1'b1;
          end
        end
        BREAK: begin
          if (rx_i) state_d = IDLE;
        end
        default: state_d = IDLE;
      endcase
    end
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_q <= IDLE;
      tick_q  <= '0;
      bit_q   <= '0;
      shreg_q <= '0;
      perr_q  <= 1'b0;
    end else if (clr_i) begin
      state_q <= IDLE;
      tick_q  <= '0;
      bit_q   <= '0;
      shreg_q <= '0;
      perr_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      tick_q  <= tick_d;
      bit_q   <= bit_d;
      shreg_q <= shreg_d;
      perr_q  <= perr_d;
    end
  end

  // Output register: a completion while an unaccepted word is held is dropped and flagged.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      data_o       <= '0;
      valid_o      <= 1'b0;
      frame_err_o  <= 1'b0;
      parity_err_o <= 1'b0;
      overrun_o    <= 1'b0;
    end else if (clr_i) begin
      data_o       <= '0;
      valid_o      <= 1'b0;
      frame_err_o  <= 1'b0;
      parity_err_o <= 1'b0;
      overrun_o    <= 1'b0;
    end else begin
      overrun_o <= 1'b0;
      if (complete) begin
        if (!valid_o || ready_i) begin
          data_o       <= shreg_q;
          frame_err_o  <= ~rx_i;
          parity_err_o <= perr_q;
          valid_o      <= 1'b1;
        end else begin
          overrun_o <= 1'b1;
        end
      end else if (valid_o && ready_i) begin
        valid_o <= 1'b0;
      end
    end
  end

  assign busy_o = (state_q != IDLE);

endmodule
